risc_controller: RTL and testbench
==================================

// Module: risc_controller
// PURPOSE
// - Control unit driving the datapath's register/ALU control inputs; the instruction-side counterpart of the datapath.
// - Holds a 16-bit instruction register (IR), decodes it, and sequences the datapath through a Moore FSM.
// - Emits sign-extended immediates sximm8/sximm5 to the datapath.
// - Handshake: s starts an instruction; w=1 means idle and ready.
// PARAMETERS
// ILLEGAL_TRAP  0  undefined instruction: 0 = return to WAIT with no side effects; 1 = enter HALT until reset
// PORTS
// clk       in   1   rising-edge clock
// reset     in   1   asynchronous, active-high reset
// s         in   1   start; sampled only in WAIT
// load      in   1   IR <= in on clk edge; honoured only in WAIT
// in        in   16  instruction word
// w         out  1   1 in WAIT (ready), else 0
// readnum   out  3   register file read index
// writenum  out  3   register file write index
// vsel      out  4   one-hot writeback select: 1000 mdata, 0100 sximm8, 0010 PC, 0001 C
// loada/loadb/loadc/loads  out 1 each  datapath register enables
// asel      out  1   1 forces A operand to 0
// bsel      out  1   1 selects sximm5 as B operand
// shift     out  2   shifter op = IR[4:3] in ALU state
// ALUop     out  2   00 add, 01 sub, 10 and, 11 not-B
// write     out  1   register file write enable
// sximm8    out  16  {{8{IR[7]}},IR[7:0]}
// sximm5    out  16  {{11{IR[4]}},IR[4:0]}
// BEHAVIOUR
// - Fields: op=IR[15:13], sub=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0].
// - Supported: 110/10 MOV Rn,#im8; 110/00 MOV Rd,Rm{,sh}; 101/00 ADD; 101/01 CMP; 101/10 AND; 101/11 MVN. All other encodings are illegal.
// - Outputs are a pure function of state and IR (Moore). Idle values, used in any state not listed:
//   enables/write/asel/bsel=0; vsel=0001; readnum/writenum/shift/ALUop=0.
// - States and transitions:
//   WAIT     -> DECODE when s=1
//   DECODE   -> WR_IMM | GET_A | GET_B | WAIT/HALT (illegal)
//   WR_IMM   vsel=0100, writenum=Rn, write=1 -> WAIT
//   GET_A    readnum=Rn, loada=1 -> GET_B (ADD/CMP/AND only)
//   GET_B    readnum=Rm, loadb=1 -> ALU
//   ALU      shift=sh, bsel=0, ALUop=sub for 101 instructions and 00 for MOV reg; asel=1 for MOV reg/MVN;
//            loadc=1 except CMP; loads=1 only for CMP
//   ALU      -> WAIT for CMP, else -> WR_REG
//   WR_REG   vsel=0001, writenum=Rd, write=1 -> WAIT
//   HALT     w=0, all idle values; exits only on reset
// - Latency: edges from the s-sampling edge until w=1 again: MOV imm 3, MOV reg/MVN 5, CMP 5, ADD/AND 6.
// - While busy (w=0), s and load are ignored. The IR is stable for the whole instruction.
// - s=1 and load=1 in the same WAIT cycle: the IR takes the new word and DECODE uses the new word.
// - s held high: a new instruction starts on the first WAIT cycle.
// - Reset (async, any time, including mid-instruction): state=WAIT, IR=0, all outputs at idle values, w=1.
//   Any pending write is dropped immediately.
// TESTING
// - Reset asserted in GET_B of an ADD -> same cycle: w=1, write/loada/loadb/loadc/loads=0, vsel=0001; no write follows.
// - load in=16'hD0FD, pulse s -> DECODE, then WR_IMM: write=1, writenum=0, vsel=0100, sximm8=16'hFFFD; w=1 on the 3rd edge.
// - in=16'hA148 (ADD R2,R1,R0,LSL#1) -> GET_A(readnum=1,loada), GET_B(readnum=0,loadb),
//   ALU(shift=01,ALUop=00,loadc=1,loads=0), WR_REG(writenum=2,write=1); w=1 on the 6th edge.
// - in=16'hA902 (CMP R1,R2) -> ALU state: ALUop=01, loads=1, loadc=0; write never asserted; s/load pulsed mid-run ignored.
// - in=16'hB861 (MVN R3,R1) -> ALU: asel=1, ALUop=11, then writenum=3.
//   in=16'hC081 (MOV R4,R1) -> ALU: asel=1, ALUop=00, then writenum=4.
// - in=16'hE000 -> ILLEGAL_TRAP=0: back to WAIT after DECODE, no enables pulsed;
//   ILLEGAL_TRAP=1: HALT with w=0 held until reset.

Source files
------------

// File: rtl/risc_controller.sv
// Instruction-side control unit: holds the IR, decodes it and drives the datapath via a Moore FSM.
// Latency: MOV imm 3, MOV reg/MVN/CMP 5, ADD/AND 6 edges from the s-sampling edge back to w=1.
// Backpressure: w=0 while busy; s and load are ignored until the FSM is back in WAIT.
module risc_controller #(
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic        load,
    input  logic [15:0] in,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic [3:0]  vsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic        write,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5
);

    typedef enum logic [2:0] {
        S_WAIT, S_DECODE, S_WR_IMM, S_GET_A, S_GET_B, S_ALU, S_WR_REG, S_HALT
    } state_t;

    typedef struct packed {
        logic       w;
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic [3:0] vsel;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [1:0] shift;
        logic [1:0] aluop;
        logic       write;
    } ctrl_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_ir;
    logic [15:0] w_ir_next;
    ctrl_t       r_ctrl;

    // Instruction classes decoded from the held IR
    logic w_is_alu;   // op 101: ADD/CMP/AND/MVN
    logic w_is_movi;
    logic w_is_movr;
    logic w_is_cmp;
    logic w_two_op;   // needs Rn fetched into A
    logic w_legal;

    assign w_is_alu  = (r_ir[15:13] == 3'b101);
    assign w_is_movi = (r_ir[15:13] == 3'b110) && (r_ir[12:11] == 2'b10);
    assign w_is_movr = (r_ir[15:13] == 3'b110) && (r_ir[12:11] == 2'b00);
    assign w_is_cmp  = w_is_alu && (r_ir[12:11] == 2'b01);
    assign w_two_op  = w_is_alu && (r_ir[12:11] != 2'b11);
    assign w_legal   = w_is_alu || w_is_movi || w_is_movr;

    // IR only accepts a new word while idle, so it is stable for the whole instruction
    assign w_ir_next = (r_state == S_WAIT && load) ? in : r_ir;

    // Moore output decode for a given state and instruction word
    function automatic ctrl_t ctrl_for(input state_t st, input logic [15:0] ir);
        ctrl_t c;
        c          = '0;
        c.vsel     = 4'b0001;
        c.w        = (st == S_WAIT);
        case (st)
            S_WR_IMM: begin
                c.vsel     = 4'b0100;
                c.writenum = ir[10:8];
                c.write    = 1'b1;
            end
            S_GET_A: begin
                c.readnum = ir[10:8];
                c.loada   = 1'b1;
            end
            S_GET_B: begin
                c.readnum = ir[2:0];
                c.loadb   = 1'b1;
            end
            S_ALU: begin
                c.shift = ir[4:3];
                c.aluop = (ir[15:13] == 3'b101) ? ir[12:11] : 2'b00;
                // MOV reg and MVN have no A operand: force it to zero
                c.asel  = (ir[15:13] == 3'b110) || (ir[12:11] == 2'b11);
                if (ir[15:13] == 3'b101 && ir[12:11] == 2'b01) begin
                    c.loads = 1'b1;
                end else begin
                    c.loadc = 1'b1;
                end
            end
            S_WR_REG: begin
                c.writenum = ir[7:5];
                c.write    = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

    // Next-state selection from current state, start and decoded instruction
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_WAIT:   if (s) w_next = S_DECODE;
            S_DECODE: begin
                if (!w_legal)      w_next = ILLEGAL_TRAP ? S_HALT : S_WAIT;
                else if (w_is_movi) w_next = S_WR_IMM;
                else if (w_two_op)  w_next = S_GET_A;
                else                w_next = S_GET_B;
            end
            S_WR_IMM: w_next = S_WAIT;
            S_GET_A:  w_next = S_GET_B;
            S_GET_B:  w_next = S_ALU;
            S_ALU:    w_next = w_is_cmp ? S_WAIT : S_WR_REG;
            S_WR_REG: w_next = S_WAIT;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_WAIT;
        endcase
    end

    // State, IR and registered outputs; reset drops any pending write at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_WAIT;
            r_ir    <= 16'h0000;
            r_ctrl  <= ctrl_for(S_WAIT, 16'h0000);
        end else begin
            r_state <= w_next;
            r_ir    <= w_ir_next;
            r_ctrl  <= ctrl_for(w_next, w_ir_next);
        end
    end

    assign w        = r_ctrl.w;
    assign readnum  = r_ctrl.readnum;
    assign writenum = r_ctrl.writenum;
    assign vsel     = r_ctrl.vsel;
    assign loada    = r_ctrl.loada;
    assign loadb    = r_ctrl.loadb;
    assign loadc    = r_ctrl.loadc;
    assign loads    = r_ctrl.loads;
    assign asel     = r_ctrl.asel;
    assign bsel     = r_ctrl.bsel;
    assign shift    = r_ctrl.shift;
    assign ALUop    = r_ctrl.aluop;
    assign write    = r_ctrl.write;
    assign sximm8   = {{8{r_ir[7]}}, r_ir[7:0]};
    assign sximm5   = {{11{r_ir[4]}}, r_ir[4:0]};

endmodule

// File: tb/tb_risc_controller.sv
// Bench for risc_controller: two instances (illegal words return to WAIT / trap to HALT).
// Expected per-cycle control bundles come from an instruction-level step list.
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
module tb_risc_controller;

    typedef struct packed {
        logic       w;
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic [3:0] vsel;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [1:0] shift;
        logic [1:0] aluop;
        logic       write;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        s;
    logic        load;
    logic [15:0] ir_in;

    logic        w0, loada0, loadb0, loadc0, loads0, asel0, bsel0, write0;
    logic [2:0]  readnum0, writenum0;
    logic [3:0]  vsel0;
    logic [1:0]  shift0, aluop0;
    logic [15:0] sximm8_0, sximm5_0;

    logic        w1, loada1, loadb1, loadc1, loads1, asel1, bsel1, write1;
    logic [2:0]  readnum1, writenum1;
    logic [3:0]  vsel1;
    logic [1:0]  shift1, aluop1;
    logic [15:0] sximm8_1, sximm5_1;

    exp_t obs0, obs1;
    assign obs0 = {w0, readnum0, writenum0, vsel0, loada0, loadb0, loadc0, loads0,
                   asel0, bsel0, shift0, aluop0, write0};
    assign obs1 = {w1, readnum1, writenum1, vsel1, loada1, loadb1, loadc1, loads1,
                   asel1, bsel1, shift1, aluop1, write1};

    int checks = 0;
    int errors = 0;
    bit halted = 1'b0;
    exp_t qm[$];
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    risc_controller #(.ILLEGAL_TRAP(1'b0)) dut0 (
        .clk(clk), .reset(reset), .s(s), .load(load), .in(ir_in),
        .w(w0), .readnum(readnum0), .writenum(writenum0), .vsel(vsel0),
        .loada(loada0), .loadb(loadb0), .loadc(loadc0), .loads(loads0),
        .asel(asel0), .bsel(bsel0), .shift(shift0), .ALUop(aluop0), .write(write0),
        .sximm8(sximm8_0), .sximm5(sximm5_0)
    );

    risc_controller #(.ILLEGAL_TRAP(1'b1)) dut1 (
        .clk(clk), .reset(reset), .s(s), .load(load), .in(ir_in),
        .w(w1), .readnum(readnum1), .writenum(writenum1), .vsel(vsel1),
        .loada(loada1), .loadb(loadb1), .loadc(loadc1), .loads(loads1),
        .asel(asel1), .bsel(bsel1), .shift(shift1), .ALUop(aluop1), .write(write1),
        .sximm8(sximm8_1), .sximm5(sximm5_1)
    );

    function automatic exp_t idle_exp(input logic wv);
        exp_t e;
        e      = '0;
        e.w    = wv;
        e.vsel = 4'b0001;
        return e;
    endfunction

    function automatic bit is_legal(input logic [15:0] ir);
        return (ir[15:13] == 3'b101) ||
               (ir[15:13] == 3'b110 && (ir[12:11] == 2'b00 || ir[12:11] == 2'b10));
    endfunction

    task automatic chk(input string tag, input exp_t obs, input exp_t expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One entry per clock edge after the start edge: what each instruction does, step by step
    task automatic build_model(input logic [15:0] ir, input bit trap);
        logic [2:0] op, rn, rd, rm;
        logic [1:0] sb, sh;
        bit   cmp, two;
        exp_t e;
        op = ir[15:13]; sb = ir[12:11]; rn = ir[10:8];
        rd = ir[7:5];   sh = ir[4:3];   rm = ir[2:0];
        qm.delete();
        qm.push_back(idle_exp(1'b0));                       // decode cycle
        if (op == 3'b110 && sb == 2'b10) begin              // MOV Rn,#im8
            e = idle_exp(1'b0); e.vsel = 4'b0100; e.writenum = rn; e.write = 1'b1;
            qm.push_back(e);
        end else if (is_legal(ir)) begin
            cmp = (op == 3'b101) && (sb == 2'b01);
            two = (op == 3'b101) && (sb != 2'b11);
            if (two) begin
                e = idle_exp(1'b0); e.readnum = rn; e.loada = 1'b1; qm.push_back(e);
            end
            e = idle_exp(1'b0); e.readnum = rm; e.loadb = 1'b1; qm.push_back(e);
            e = idle_exp(1'b0);
            e.shift = sh;
            e.aluop = (op == 3'b101) ? sb : 2'b00;
            e.asel  = !two;
            e.loadc = !cmp;
            e.loads = cmp;
            qm.push_back(e);
            if (!cmp) begin
                e = idle_exp(1'b0); e.writenum = rd; e.write = 1'b1; qm.push_back(e);
            end
        end else if (trap) begin
            qm.push_back(idle_exp(1'b0));                   // halted for good
            return;
        end
        qm.push_back(idle_exp(1'b1));                       // back to ready
    endtask

    // Start an instruction from WAIT (called on a falling edge) and check every cycle
    task automatic run_instr(input logic [15:0] ir, input bit junk, input string tag);
        logic [15:0] e8, e5;
        e8 = {{8{ir[7]}}, ir[7:0]};
        e5 = {{11{ir[4]}}, ir[4:0]};
        build_model(ir, 1'b0); q0 = qm;
        build_model(ir, 1'b1); q1 = qm;
        if (halted) begin
            foreach (q1[i]) q1[i] = idle_exp(1'b0);
        end
        ir_in = ir; load = 1'b1; s = 1'b1;
        for (int k = 0; k < q0.size(); k++) begin
            @(negedge clk);
            chk($sformatf("%s_d0_step%0d", tag, k), obs0, q0[k]);
            chk($sformatf("%s_d1_step%0d", tag, k), obs1, q1[k]);
            chk16($sformatf("%s_sximm8_step%0d", tag, k), sximm8_0, e8);
            chk16($sformatf("%s_sximm5_step%0d", tag, k), sximm5_0, e5);
            if (junk && k < q0.size() - 1) begin
                s = 1'($urandom); load = 1'($urandom); ir_in = 16'($urandom);
            end else begin
                s = 1'b0; load = 1'b0;
            end
        end
        if (!is_legal(ir)) halted = 1'b1;
    endtask

    initial begin
        logic [31:0] r;
        logic [15:0] ir;
        int          cls;
        exp_t        e;

        reset = 1'b1; s = 1'b0; load = 1'b0; ir_in = 16'h0000;
        #12;
        chk("reset_d0", obs0, idle_exp(1'b1));
        chk("reset_d1", obs1, idle_exp(1'b1));
        chk16("reset_sximm8", sximm8_0, 16'h0000);
        chk16("reset_sximm5", sximm5_0, 16'h0000);
        @(negedge clk);
        reset = 1'b0;

        // Reset in the middle of an ADD, while in GET_B
        ir_in = 16'hA148; load = 1'b1; s = 1'b1;
        @(negedge clk); s = 1'b0; load = 1'b0;
        @(negedge clk);
        @(negedge clk);
        e = idle_exp(1'b0); e.readnum = 3'd0; e.loadb = 1'b1;
        chk("add_get_b", obs0, e);
        #1 reset = 1'b1;
        #1;
        chk("midrst_d0", obs0, idle_exp(1'b1));
        chk("midrst_d1", obs1, idle_exp(1'b1));
        chk16("midrst_ir", sximm8_0, 16'h0000);
        @(negedge clk); reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("postrst_%0d", k), obs0, idle_exp(1'b1));
        end

        // Directed instructions
        run_instr(16'hD0FD, 1'b0, "movi");
        run_instr(16'hA148, 1'b0, "add");
        run_instr(16'hA902, 1'b1, "cmp");
        run_instr(16'hB861, 1'b0, "mvn");
        run_instr(16'hC081, 1'b0, "movr");

        // Random legal instructions, with junk on s/load/in while busy
        for (int n = 0; n < 40; n++) begin
            r   = $urandom;
            cls = $urandom_range(0, 5);
            case (cls)
                0:       ir = {3'b110, 2'b10, r[10:0]};
                1:       ir = {3'b110, 2'b00, r[10:0]};
                default: ir = {3'b101, 2'(cls - 2), r[10:0]};
            endcase
            run_instr(ir, 1'b1, $sformatf("rand%0d", n));
        end

        // Illegal words: dut0 keeps going, dut1 halts on the first one
        run_instr(16'hE000, 1'b0, "ill_e000");
        for (int n = 0; n < 3; n++) begin
            do r = $urandom; while (is_legal(r[15:0]));
            run_instr(r[15:0], 1'b1, $sformatf("ill%0d", n));
        end
        run_instr(16'hA148, 1'b0, "add_while_halted");

        // Only reset leaves HALT
        reset = 1'b1;
        #1;
        chk("halt_rst_d1", obs1, idle_exp(1'b1));
        @(negedge clk); reset = 1'b0; halted = 1'b0;
        run_instr(16'hD0FD, 1'b0, "movi_after_halt");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
